// File: rtl/fetch_pkg.sv
// Shared definitions for the myMIPS fetch stage: FSM encoding, null instruction,
// default PC width and the control-transfer opcodes decode also uses.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SQUASH = 2'd2
    } fetch_state_t;

    localparam logic [15:0] NOP_INSTR    = 16'h0000;
    localparam int          PC_W_DEFAULT = 12;

    localparam logic [3:0] OP_BEQ = 4'h4;
    localparam logic [3:0] OP_J   = 4'h8;
    localparam logic [3:0] OP_JAL = 4'h9;

    // Width able to hold 0..slots, never narrower than one bit.
    function automatic int ctr_width(input int slots);
        return (slots < 1) ? 1 : $clog2(slots + 1);
    endfunction

endpackage

// File: rtl/fetch_squash_ctr.sv
// Loadable down-counter tracking the remaining squashed fetch slots after a redirect.
// Holds when i_dec is low and stops at zero.
module fetch_squash_ctr
    import fetch_pkg::*;
#(
    parameter int SQUASH_SLOTS = 3,
    localparam int CW = ctr_width(SQUASH_SLOTS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_done
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CW'(SQUASH_SLOTS);
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_count = r_count;
    assign o_done  = (r_count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous ROM and blanks slots
// after redirects. Optional perf counters are enabled with FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W         = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter int              SQUASH_SLOTS = 3
) (
    input  logic            clk,
    input  logic            rst,
    output logic            rom_rd,
    output logic [PC_W-1:0] rom_addr,
    input  logic [15:0]     rom_data,
    output logic [15:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic [PC_W-1:0] pc_plus1,
    output logic            instr_valid,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
    , output logic [31:0]   fetch_cnt
    , output logic [31:0]   squash_cnt
`endif
);

    localparam int              CW     = ctr_width(SQUASH_SLOTS);
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_instr_pc;
    logic            r_rd_q;
    logic            w_running;
    logic            w_redir;
    logic            w_advance;
    logic            w_squash;
    logic            w_dec;
    logic [CW-1:0]   w_cnt;
    logic            w_done;

    assign w_running = (r_state != ST_BOOT);
    assign w_redir   = w_running && redirect_valid;
    assign w_advance = w_running && !redirect_valid && !stall;
    assign w_squash  = (r_state == ST_SQUASH);
    assign w_dec     = w_squash && w_advance;

    fetch_squash_ctr #(
        .SQUASH_SLOTS(SQUASH_SLOTS)
    ) u_squash_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_redir),
        .i_dec  (w_dec),
        .o_count(w_cnt),
        .o_done (w_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        rom_rd      = w_running;
        rom_addr    = r_pc;
        if (w_redir) begin
            rom_addr = redirect_pc;
        end else if (w_running && stall) begin
            // Re-read the word on instr so it stays stable through the stall.
            rom_addr = r_instr_pc;
        end
        if (w_redir) begin
            w_state_nxt = (SQUASH_SLOTS == 0) ? ST_RUN : ST_SQUASH;
        end else begin
            case (r_state)
                ST_BOOT:   w_state_nxt = ST_RUN;
                ST_RUN:    w_state_nxt = ST_RUN;
                ST_SQUASH: begin
                    if (w_done || (w_dec && (w_cnt == CW'(1)))) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default:   w_state_nxt = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_instr_pc <= RESET_PC;
            r_rd_q     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rd_q  <= rom_rd;
            if (w_redir || w_advance) begin
                r_pc       <= rom_addr + PC_ONE;
                r_instr_pc <= rom_addr;
            end
        end
    end

    // ROM data is gated combinationally; no extra register on the fetch path.
    assign instr       = (w_squash || !r_rd_q) ? NOP_INSTR : rom_data;
    assign instr_valid = r_rd_q && !w_squash;
    assign instr_pc    = r_instr_pc;
    assign pc_plus1    = r_instr_pc + PC_ONE;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_squash_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_cnt  <= '0;
            r_squash_cnt <= '0;
        end else begin
            if (instr_valid && !stall && (r_fetch_cnt != '1)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_squash && !stall && (r_squash_cnt != '1)) begin
                r_squash_cnt <= r_squash_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign squash_cnt = r_squash_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against an
// instruction-stream model. Perf-counter checks compile in with FETCH_PERF_CNT_EN.
module tb_fetch_unit;

    localparam int SLOTS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rom_rd;
    logic [11:0] rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic [11:0] pc_plus1;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_pc = 12'h000;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] squash_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(
        .PC_W(12), .RESET_PC(12'h000), .SQUASH_SLOTS(SLOTS)
    ) dut (
        .clk(clk), .rst(rst), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr(instr), .instr_pc(instr_pc), .pc_plus1(pc_plus1), .instr_valid(instr_valid),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .squash_cnt(squash_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [11:0] a);
        return 16'h1000 + {4'h0, a};
    endfunction

    always_ff @(posedge clk) begin
        if (rom_rd) rom_data <= rom_word(rom_addr);
    end

    // Model of the presented stream: which address is on instr, the next address
    // to fetch, and how many upcoming presented slots (including this one) are blank.
    bit          m_boot    = 1'b1;
    bit          m_fetched = 1'b0;
    logic [11:0] m_pres    = 12'h000;
    logic [11:0] m_next    = 12'h000;
    int          m_left    = 0;
    longint      m_fcnt    = 0;
    longint      m_scnt    = 0;

    function automatic void model_edge();
        if (!rst) begin
            m_boot = 1'b1; m_fetched = 1'b0; m_pres = 12'h000; m_next = 12'h000;
            m_left = 0; m_fcnt = 0; m_scnt = 0;
        end else begin
            if (!stall && m_fetched && m_left == 0) m_fcnt++;
            if (!stall && m_left != 0) m_scnt++;
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (redirect_valid) begin
                m_pres = redirect_pc; m_next = redirect_pc + 12'd1; m_left = SLOTS; m_fetched = 1'b1;
            end else if (stall) begin
                m_fetched = 1'b1;
            end else begin
                m_pres = m_next; m_next = m_next + 12'd1; m_fetched = 1'b1;
                if (m_left > 0) m_left--;
            end
        end
    endfunction

    function automatic logic [15:0] exp_instr();
        return (!m_fetched || m_left != 0) ? 16'h0000 : rom_word(m_pres);
    endfunction

    function automatic logic [11:0] exp_addr();
        if (redirect_valid) return redirect_pc;
        if (stall) return m_pres;
        return m_next;
    endfunction

    task automatic apply(input logic r, input logic s, input logic rv, input logic [11:0] rp);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        apply(1'b0, 1'b0, 1'b0, 12'h000);
        tick(); tick();
        n_tests++; if (rom_rd !== 1'b0) begin n_fail++; $display("FAIL rst_rd got %b want 0", rom_rd); end
        n_tests++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL rst_instr got %h want 0000", instr); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", instr_valid); end
        n_tests++; if (instr_pc !== 12'h000) begin n_fail++; $display("FAIL rst_ipc got %h want 000", instr_pc); end
        apply(1'b1, 1'b0, 1'b0, 12'h000);
        tick();
        n_tests++; if (instr_valid !== 1'b0 || instr !== 16'h0000) begin n_fail++; $display("FAIL boot_out got %b/%h want 0/0000", instr_valid, instr); end
        n_tests++; if (rom_rd !== 1'b1 || rom_addr !== 12'h000) begin n_fail++; $display("FAIL run_first got %b/%h want 1/000", rom_rd, rom_addr); end
    endtask

    task automatic test_sequential();
        tick();
        n_tests++; if (instr !== 16'h1000 || instr_pc !== 12'h000 || pc_plus1 !== 12'h001) begin n_fail++; $display("FAIL seq0 got %h/%h/%h want 1000/000/001", instr, instr_pc, pc_plus1); end
        n_tests++; if (instr_valid !== 1'b1 || rom_addr !== 12'h001) begin n_fail++; $display("FAIL seq0_v got %b/%h want 1/001", instr_valid, rom_addr); end
        tick();
        n_tests++; if (instr !== 16'h1001 || instr_pc !== 12'h001 || pc_plus1 !== 12'h002) begin n_fail++; $display("FAIL seq1 got %h/%h/%h want 1001/001/002", instr, instr_pc, pc_plus1); end
        n_tests++; if (rom_addr !== 12'h002) begin n_fail++; $display("FAIL seq1_addr got %h want 002", rom_addr); end
        repeat (4) tick();
        n_tests++; if (instr !== 16'h1005 || instr_pc !== 12'h005) begin n_fail++; $display("FAIL seq5 got %h/%h want 1005/005", instr, instr_pc); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 1'b0, 12'h000);
            n_tests++; if (rom_addr !== 12'h005 || rom_rd !== 1'b1) begin n_fail++; $display("FAIL stall_addr%0d got %h/%b want 005/1", i, rom_addr, rom_rd); end
            tick();
            n_tests++; if (instr !== 16'h1005 || instr_pc !== 12'h005 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d got %h/%h/%b want 1005/005/1", i, instr, instr_pc, instr_valid); end
        end
        apply(1'b1, 1'b0, 1'b0, 12'h000);
        n_tests++; if (rom_addr !== 12'h006) begin n_fail++; $display("FAIL stall_rel_addr got %h want 006", rom_addr); end
        tick();
        n_tests++; if (instr !== 16'h1006 || instr_pc !== 12'h006) begin n_fail++; $display("FAIL stall_rel got %h/%h want 1006/006", instr, instr_pc); end
        tick();
        n_tests++; if (instr !== 16'h1007 || instr_pc !== 12'h007) begin n_fail++; $display("FAIL stall_next got %h/%h want 1007/007", instr, instr_pc); end
    endtask

    task automatic test_redirect();
        apply(1'b1, 1'b0, 1'b1, 12'h040);
        n_tests++; if (rom_addr !== 12'h040) begin n_fail++; $display("FAIL redir_bypass got %h want 040", rom_addr); end
        tick();
        apply(1'b1, 1'b0, 1'b0, 12'h000);
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (instr !== 16'h0000 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_sq%0d got %h/%b want 0000/0", i, instr, instr_valid); end
            tick();
        end
        n_tests++; if (instr !== 16'h1043 || instr_pc !== 12'h043 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL redir_land got %h/%h/%b want 1043/043/1", instr, instr_pc, instr_valid); end
`ifdef FETCH_PERF_CNT_EN
        n_tests++; if (squash_cnt !== 32'd3) begin n_fail++; $display("FAIL perf_squash got %0d want 3", squash_cnt); end
        n_tests++; if (fetch_cnt !== 32'(m_fcnt)) begin n_fail++; $display("FAIL perf_fetch got %0d want %0d", fetch_cnt, m_fcnt); end
`endif
    endtask

    task automatic test_back_to_back();
        apply(1'b1, 1'b0, 1'b1, 12'h040);
        tick();
        apply(1'b1, 1'b0, 1'b1, 12'h080);
        n_tests++; if (rom_addr !== 12'h080) begin n_fail++; $display("FAIL b2b_addr got %h want 080", rom_addr); end
        tick();
        apply(1'b1, 1'b0, 1'b0, 12'h000);
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (instr_valid !== 1'b0 || instr !== 16'h0000) begin n_fail++; $display("FAIL b2b_sq%0d got %b/%h want 0/0000", i, instr_valid, instr); end
            tick();
        end
        n_tests++; if (instr !== 16'h1083 || instr_pc !== 12'h083) begin n_fail++; $display("FAIL b2b_land got %h/%h want 1083/083", instr, instr_pc); end
        apply(1'b1, 1'b1, 1'b1, 12'h100);
        n_tests++; if (rom_addr !== 12'h100) begin n_fail++; $display("FAIL stallredir_addr got %h want 100", rom_addr); end
        tick();
        apply(1'b1, 1'b0, 1'b0, 12'h000);
        repeat (3) tick();
        n_tests++; if (instr !== 16'h1103 || instr_pc !== 12'h103) begin n_fail++; $display("FAIL stallredir_land got %h/%h want 1103/103", instr, instr_pc); end
    endtask

    task automatic test_wrap();
        apply(1'b1, 1'b0, 1'b1, 12'hFFC);
        tick();
        apply(1'b1, 1'b0, 1'b0, 12'h000);
        repeat (3) tick();
        n_tests++; if (instr !== 16'h1FFF || instr_pc !== 12'hFFF || pc_plus1 !== 12'h000) begin n_fail++; $display("FAIL wrap_top got %h/%h/%h want 1fff/fff/000", instr, instr_pc, pc_plus1); end
        n_tests++; if (rom_addr !== 12'h000) begin n_fail++; $display("FAIL wrap_addr got %h want 000", rom_addr); end
        tick();
        n_tests++; if (instr !== 16'h1000 || instr_pc !== 12'h000) begin n_fail++; $display("FAIL wrap_next got %h/%h want 1000/000", instr, instr_pc); end
    endtask

    task automatic test_reset_mid();
        apply(1'b1, 1'b0, 1'b1, 12'h200);
        tick();
        apply(1'b0, 1'b1, 1'b0, 12'h000);
        tick();
        n_tests++; if (rom_rd !== 1'b0 || instr !== 16'h0000 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out got %b/%h/%b want 0/0000/0", rom_rd, instr, instr_valid); end
        n_tests++; if (instr_pc !== 12'h000 || rom_addr !== 12'h000) begin n_fail++; $display("FAIL rstmid_pc got %h/%h want 000/000", instr_pc, rom_addr); end
`ifdef FETCH_PERF_CNT_EN
        n_tests++; if (fetch_cnt !== 32'd0 || squash_cnt !== 32'd0) begin n_fail++; $display("FAIL rstmid_perf got %0d/%0d want 0/0", fetch_cnt, squash_cnt); end
`endif
        apply(1'b1, 1'b0, 1'b0, 12'h000);
        tick();
        n_tests++; if (rom_rd !== 1'b1 || rom_addr !== 12'h000) begin n_fail++; $display("FAIL rstmid_run got %b/%h want 1/000", rom_rd, rom_addr); end
    endtask

    task automatic test_random();
        logic r, s, rv;
        logic [11:0] rp;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) >= 2);
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 7) == 0);
            rp = ($urandom_range(0, 3) == 0) ? 12'(12'hFF8 + $urandom_range(0, 7)) : 12'($urandom_range(0, 4095));
            apply(r, s, rv, rp);
            n_tests++; if (rom_rd !== !m_boot) begin n_fail++; $display("FAIL rnd%0d_rd got %b want %b", i, rom_rd, !m_boot); end
            if (!m_boot) begin
                n_tests++; if (rom_addr !== exp_addr()) begin n_fail++; $display("FAIL rnd%0d_addr got %h want %h", i, rom_addr, exp_addr()); end
            end
            n_tests++; if (instr !== exp_instr()) begin n_fail++; $display("FAIL rnd%0d_instr got %h want %h", i, instr, exp_instr()); end
            n_tests++; if (instr_valid !== (m_fetched && m_left == 0)) begin n_fail++; $display("FAIL rnd%0d_valid got %b want %b", i, instr_valid, (m_fetched && m_left == 0)); end
            n_tests++; if (instr_pc !== m_pres || pc_plus1 !== 12'(m_pres + 12'd1)) begin n_fail++; $display("FAIL rnd%0d_pc got %h/%h want %h", i, instr_pc, pc_plus1, m_pres); end
`ifdef FETCH_PERF_CNT_EN
            n_tests++; if (fetch_cnt !== 32'(m_fcnt) || squash_cnt !== 32'(m_scnt)) begin n_fail++; $display("FAIL rnd%0d_perf got %0d/%0d want %0d/%0d", i, fetch_cnt, squash_cnt, m_fcnt, m_scnt); end
`endif
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
